mem_responder: RTL

- Memory-side responder for the multicycle CPU's load/store/fetch accesses.
- Accepts one request at a time on a req/ack handshake and serves it after a programmable number of wait states.
- Byte-addressed, word-aligned 32-bit RAM with big-endian byte numbering.
- The highest word holds the exception treatment-vector bytes that the CPU reads at byte address 252.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/word_ram.sv | 40 ++++
 rtl/mem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder slice.
// Contents: FSM state encoding, word size constant, address-legality check.
// Used by: mem_responder (FSM, request capture) and its testbench.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned OFS_BITS   = $clog2(WORD_BYTES);

    // A request is rejected when it is not word aligned or lands past the
    // last word of the array.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/word_ram.sv
// Word-wide RAM: synchronous write, registered read, async reset to zeros
// with the top word preset to VEC_INIT (exception vector bytes).
// Ports: clock/reset, we+widx+wdata write, re+widx registered read to rdata.
module word_ram #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] VEC_INIT    = 32'h0000_FEFF,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Whole-array reset so the CPU always boots with a known vector word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= (i == int'(DEPTH_WORDS) - 1) ? VEC_INIT : 32'h0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Read register only moves on a read strobe, so it holds between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= 32'h0;
        end else if (re) begin
            rdata <= mem[widx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the multicycle CPU: one request at a time, served
// after WAIT_CYCLES wait states; Ack is a one-cycle pulse, AddrErr valid with it.
// Ports: clock/reset, Req/Wr/Address/Datain in, Dataout/Ack/AddrErr/Busy out.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] VEC_INIT    = 32'h0000_FEFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Ack,
    output logic        AddrErr,
    output logic        Busy
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state, next_state;
    logic [3:0]        cnt;
    logic              cap_wr;
    logic              cap_err;
    logic [IDX_W-1:0]  cap_idx;
    logic [31:0]       cap_data;
    logic              out_zero;

    logic              in_idle;
    logic              eff_wr;
    logic              eff_err;
    logic [IDX_W-1:0]  eff_idx;
    logic [31:0]       eff_data;
    logic              enter_resp;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and status outputs.
    always_comb begin
        next_state = state;
        Ack        = 1'b0;
        AddrErr    = 1'b0;
        Busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (Req) begin
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                Busy = 1'b1;
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                Busy       = 1'b1;
                Ack        = 1'b1;
                AddrErr    = cap_err;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states the RAM access happens on the same edge that
    // samples Req, so the live inputs stand in for the not-yet-captured ones.
    assign in_idle    = (state == IDLE);
    assign eff_wr     = in_idle ? Wr : cap_wr;
    assign eff_err    = in_idle ? addr_err(Address, 32'(DEPTH_WORDS)) : cap_err;
    assign eff_idx    = in_idle ? Address[OFS_BITS +: IDX_W] : cap_idx;
    assign eff_data   = in_idle ? Datain : cap_data;
    assign enter_resp = (next_state == RESP);
    assign ram_we     = enter_resp && eff_wr && !eff_err;
    assign ram_re     = enter_resp && !eff_wr && !eff_err;

    // Request capture and wait counter; captured fields are frozen until
    // the next IDLE, so input wiggles during WAIT are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= 4'd0;
            cap_wr   <= 1'b0;
            cap_err  <= 1'b0;
            cap_idx  <= '0;
            cap_data <= 32'h0;
        end else if (in_idle && Req) begin
            cnt      <= WAIT_LOAD;
            cap_wr   <= Wr;
            cap_err  <= addr_err(Address, 32'(DEPTH_WORDS));
            cap_idx  <= Address[OFS_BITS +: IDX_W];
            cap_data <= Datain;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Dataout forcing: a rejected request shows zero, a good read shows the
    // RAM read register, a good write leaves whatever was shown before.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_zero <= 1'b1;
        end else if (enter_resp) begin
            if (eff_err) begin
                out_zero <= 1'b1;
            end else if (!eff_wr) begin
                out_zero <= 1'b0;
            end
        end
    end

    assign Dataout = out_zero ? 32'h0 : ram_rdata;

    word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .VEC_INIT    (VEC_INIT),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .widx  (eff_idx),
        .wdata (eff_data),
        .rdata (ram_rdata)
    );

endmodule
